// File: rtl/ifft_butterfly_pipe_pkg.sv
// Shared widths and the round/saturate helper used by the IFFT butterfly stages.
package fft_pkg;
  localparam int IN_W    = 50;
  localparam int IN_FRAC = 28;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;
  localparam int OUT_W   = 50;
  localparam int SUM_W   = IN_W + 1;
  localparam int PROD_W  = 68;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] val;
  } rs_t;

  // Round-half-up by 'sh' bits, then clamp to a signed 'ow'-bit range.
  function automatic rs_t round_sat(input logic signed [PROD_W-1:0] v,
                                    input int sh, input int ow);
    logic signed [PROD_W:0] t, one, hi, lo;
    rs_t r;
    one = (PROD_W+1)'(1);
    t   = {v[PROD_W-1], v};
    if (sh > 0) t = t + (one <<< (sh - 1));
    t  = t >>> sh;
    hi = (one <<< (ow - 1)) - one;
    lo = -(one <<< (ow - 1));
    r.sat = (t > hi) || (t < lo);
    if (t > hi)      r.val = hi[OUT_W-1:0];
    else if (t < lo) r.val = lo[OUT_W-1:0];
    else             r.val = t[OUT_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/ifft_butterfly_pipe_if.sv
// Pair-in / pair-out handshake bundle for one butterfly stage.
interface ifft_butterfly_pipe_if;
  import fft_pkg::*;
  logic                    in_valid, in_ready, out_valid, out_ready;
  logic signed [IN_W-1:0]  a_real, a_imag, b_real, b_imag;
  logic signed [TW_W-1:0]  tw_real, tw_imag;
  logic signed [OUT_W-1:0] o1_real, o1_imag, o2_real, o2_imag;

  modport master (output in_valid, a_real, a_imag, b_real, b_imag, tw_real, tw_imag, out_ready,
                  input  in_ready, out_valid, o1_real, o1_imag, o2_real, o2_imag);
  modport slave  (input  in_valid, a_real, a_imag, b_real, b_imag, tw_real, tw_imag, out_ready,
                  output in_ready, out_valid, o1_real, o1_imag, o2_real, o2_imag);
endinterface

// File: rtl/ifft_butterfly_pipe_mult.sv
// Registered complex multiply d * conj(w); one pipeline stage.
module cplx_conj_mult
  import fft_pkg::*;
#(
  parameter int DW = SUM_W,
  parameter int WW = TW_W,
  parameter int PW = PROD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [DW-1:0] dr,
  input  logic signed [DW-1:0] di,
  input  logic signed [WW-1:0] wr,
  input  logic signed [WW-1:0] wi,
  output logic signed [PW-1:0] pr,
  output logic signed [PW-1:0] pi
);
  logic signed [PW-1:0] rr, ii, ir, ri;

  assign rr = PW'(dr) * PW'(wr);
  assign ii = PW'(di) * PW'(wi);
  assign ir = PW'(di) * PW'(wr);
  assign ri = PW'(dr) * PW'(wi);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr <= '0;
      pi <= '0;
    end else if (en) begin
      pr <= rr + ii;
      pi <= ir - ri;
    end
  end
endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Radix-2 DIF inverse butterfly: S1 sum/diff, S2 conj-twiddle multiply, S3 round/saturate.
module ifft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int SCALE = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifft_butterfly_pipe_if.slave bus,
  input  logic                 sat_clr,
  output logic                 sat_flag,
  output logic [CNT_W-1:0]     pair_cnt
);
  localparam int STAGES = 3;

  logic                     en, acc, any_sat;
  logic [STAGES:1]          vld_pipe;
  logic signed [SUM_W-1:0]  s1_r, s1_i, d1_r, d1_i, s2_r, s2_i;
  logic signed [TW_W-1:0]   w1_r, w1_i;
  logic signed [PROD_W-1:0] p_r, p_i;
  rs_t                      rs1r, rs1i, rs2r, rs2i;

  // One global enable: bubbles stay in place, the whole pipe freezes on stall.
  assign en            = !bus.out_valid || bus.out_ready;
  assign acc           = bus.in_valid && en;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r <= '0; s1_i <= '0; d1_r <= '0; d1_i <= '0;
      w1_r <= '0; w1_i <= '0;
    end else if (acc) begin
      s1_r <= SUM_W'(bus.a_real) + SUM_W'(bus.b_real);
      s1_i <= SUM_W'(bus.a_imag) + SUM_W'(bus.b_imag);
      d1_r <= SUM_W'(bus.a_real) - SUM_W'(bus.b_real);
      d1_i <= SUM_W'(bus.a_imag) - SUM_W'(bus.b_imag);
      w1_r <= bus.tw_real;
      w1_i <= bus.tw_imag;
    end
  end

  cplx_conj_mult u_mult (
    .clk(clk), .rst_n(rst_n), .en(en),
    .dr(d1_r), .di(d1_i), .wr(w1_r), .wi(w1_i),
    .pr(p_r), .pi(p_i)
  );

  always_comb begin
    rs1r    = round_sat(PROD_W'(s2_r), SCALE, OUT_W);
    rs1i    = round_sat(PROD_W'(s2_i), SCALE, OUT_W);
    rs2r    = round_sat(p_r, TW_FRAC + SCALE, OUT_W);
    rs2i    = round_sat(p_i, TW_FRAC + SCALE, OUT_W);
    any_sat = rs1r.sat | rs1i.sat | rs2r.sat | rs2i.sat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s2_r        <= '0;
      s2_i        <= '0;
      bus.o1_real <= '0;
      bus.o1_imag <= '0;
      bus.o2_real <= '0;
      bus.o2_imag <= '0;
      sat_flag    <= 1'b0;
      pair_cnt    <= '0;
    end else begin
      if (en) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], acc};
        s2_r     <= s1_r;
        s2_i     <= s1_i;
      end
      if (en && vld_pipe[2]) begin
        bus.o1_real <= rs1r.val;
        bus.o1_imag <= rs1i.val;
        bus.o2_real <= rs2r.val;
        bus.o2_imag <= rs2i.val;
      end
      // A new saturation event outranks a simultaneous clear.
      if (en && vld_pipe[2] && any_sat) sat_flag <= 1'b1;
      else if (sat_clr)                 sat_flag <= 1'b0;
      if (bus.out_valid && bus.out_ready) pair_cnt <= pair_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Scoreboard bench: drivers push expected pairs, per-instance monitors pop on handshake.
module tb_ifft_butterfly_pipe;
  typedef struct { longint ar, ai, br, bi, wr, wi; } vin_t;
  typedef struct { longint o1r, o1i, o2r, o2i; } exp_t;

  localparam longint MAXV = 64'sd562949953421311;
  localparam longint MINV = -64'sd562949953421312;

  logic        clk, rst_n, clr1, clr0, sf1, sf0;
  logic [15:0] pc1, pc0;
  int          errors = 0, checks = 0;
  exp_t        q1[$], q0[$];

  ifft_butterfly_pipe_if b1();
  ifft_butterfly_pipe_if b0();

  ifft_butterfly_pipe #(.SCALE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .sat_clr(clr1), .sat_flag(sf1), .pair_cnt(pc1));
  ifft_butterfly_pipe #(.SCALE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .sat_clr(clr0), .sat_flag(sf0), .pair_cnt(pc0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vin_t mkv(longint ar, longint ai, longint br, longint bi, longint wr, longint wi);
    vin_t v;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.wr = wr; v.wi = wi;
    return v;
  endfunction

  function automatic exp_t mke(longint o1r, longint o1i, longint o2r, longint o2i);
    exp_t e;
    e.o1r = o1r; e.o1i = o1i; e.o2r = o2r; e.o2i = o2i;
    return e;
  endfunction

  task automatic check(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic put(input int which, input vin_t v, input logic vld);
    if (which == 1) begin
      b1.in_valid = vld;
      b1.a_real = 50'(v.ar); b1.a_imag = 50'(v.ai);
      b1.b_real = 50'(v.br); b1.b_imag = 50'(v.bi);
      b1.tw_real = 16'(v.wr); b1.tw_imag = 16'(v.wi);
    end else begin
      b0.in_valid = vld;
      b0.a_real = 50'(v.ar); b0.a_imag = 50'(v.ai);
      b0.b_real = 50'(v.br); b0.b_imag = 50'(v.bi);
      b0.tw_real = 16'(v.wr); b0.tw_imag = 16'(v.wi);
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 1) ? b1.in_ready : b0.in_ready;
  endfunction

  function automatic int qsz(input int which);
    return (which == 1) ? q1.size() : q0.size();
  endfunction

  task automatic drive(input int which, input vin_t v, input exp_t e);
    int n;
    @(negedge clk);
    put(which, v, 1'b1);
    #1;
    n = 0;
    while (!rdy(which) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout u%0d: got no in_ready, expected accept", which);
    end else if (which == 1) q1.push_back(e);
    else q0.push_back(e);
    @(posedge clk); #1;
    put(which, v, 1'b0);
  endtask

  task automatic drain(input int which);
    for (int i = 0; i < 100; i++) begin
      if (qsz(which) == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check($sformatf("u%0d_drain_left", which), qsz(which), 0);
  endtask

  task automatic chk_pop(input int which);
    exp_t   e;
    longint g1r, g1i, g2r, g2i;
    if (which == 1) begin
      g1r = b1.o1_real; g1i = b1.o1_imag; g2r = b1.o2_real; g2i = b1.o2_imag;
    end else begin
      g1r = b0.o1_real; g1i = b0.o1_imag; g2r = b0.o2_real; g2i = b0.o2_imag;
    end
    if (qsz(which) == 0) begin
      checks++; errors++;
      $display("FAIL u%0d_unexpected_out: got o1_real %0d, expected no output", which, g1r);
      return;
    end
    e = (which == 1) ? q1.pop_front() : q0.pop_front();
    check($sformatf("u%0d_o1_real", which), g1r, e.o1r);
    check($sformatf("u%0d_o1_imag", which), g1i, e.o1i);
    check($sformatf("u%0d_o2_real", which), g2r, e.o2r);
    check($sformatf("u%0d_o2_imag", which), g2i, e.o2i);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && b1.out_valid && b1.out_ready) chk_pop(1);
    if (rst_n && b0.out_valid && b0.out_ready) chk_pop(0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vin_t z;
    int   n;
    z = mkv(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; clr1 = 1'b0; clr0 = 1'b0;
    put(1, z, 1'b0); put(0, z, 1'b0);
    b1.out_ready = 1'b1; b0.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", b1.out_valid, 0);
    check("rst_o1_real", b1.o1_real, 0);
    check("rst_o2_imag", b1.o2_imag, 0);
    check("rst_sat_flag", sf1, 0);
    check("rst_pair_cnt", pc1, 0);
    check("rst_u0_out_valid", b0.out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", b1.in_ready, 1);

    // Directed vectors, SCALE=1
    drive(1, mkv(268435456, 0, 134217728, 0, 16384, 0), mke(201326592, 0, 67108864, 0));
    drive(1, mkv(268435456, 0, 0, 0, 0, -16384),        mke(134217728, 0, 0, 134217728));
    drive(1, mkv(-3, 0, 0, 0, 16384, 0),                mke(-1, 0, -1, 0));
    drive(1, mkv(3, 0, 0, 0, 16384, 0),                 mke(2, 0, 2, 0));
    drain(1);
    check("u1_pair_cnt_4", pc1, 4);
    check("u1_no_sat", sf1, 0);

    // Saturation, SCALE=0
    drive(0, mkv(MAXV, 0, MAXV, 0, 16384, 0), mke(MAXV, 0, 0, 0));
    drive(0, mkv(MINV, 0, MINV, 0, 16384, 0), mke(MINV, 0, 0, 0));
    drain(0);
    check("u0_sat_set", sf0, 1);
    check("u0_pair_cnt_2", pc0, 2);
    @(negedge clk) clr0 = 1'b1;
    @(negedge clk) clr0 = 1'b0;
    check("u0_sat_clr", sf0, 0);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("u1_cnt_after_rst", pc1, 0);

    // Backpressure: out_ready low for cycles 4..8 of the stream
    fork
      for (int k = 1; k <= 6; k++)
        drive(1, mkv(4*k, 2*k, 2*k, 0, 16384, 0), mke(3*k, k, k, k));
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        b1.out_ready = !(c >= 4 && c <= 8);
        #1;
        if (!b1.out_ready && b1.out_valid) check($sformatf("stall_in_ready_c%0d", c), b1.in_ready, 0);
      end
    join
    b1.out_ready = 1'b1;
    drain(1);
    check("u1_pair_cnt_6", pc1, 6);

    // Reset with three pairs in flight on each instance
    b1.out_ready = 1'b0; b0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      put(1, mkv(100, 0, 0, 0, 16384, 0), 1'b1);
      put(0, mkv(MAXV, 0, MAXV, 0, 16384, 0), 1'b1);
      #1;
      check($sformatf("fill_in_ready_%0d", i), b1.in_ready, 1);
    end
    @(negedge clk);
    put(1, z, 1'b0); put(0, z, 1'b0);
    check("fill_out_valid", b1.out_valid, 1);
    check("fill_u0_sat", sf0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", b1.out_valid, 0);
    check("midrst_u0_out_valid", b0.out_valid, 0);
    check("midrst_pair_cnt", pc1, 0);
    check("midrst_u0_sat", sf0, 0);
    rst_n = 1'b1;
    b1.out_ready = 1'b1; b0.out_ready = 1'b1;

    @(negedge clk);
    put(1, mkv(268435456, 0, 134217728, 0, 16384, 0), 1'b1);
    #1;
    check("relaunch_in_ready", b1.in_ready, 1);
    q1.push_back(mke(201326592, 0, 67108864, 0));
    @(posedge clk); #1;
    put(1, z, 1'b0);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!b1.out_valid && n < 10);
    check("relaunch_latency", n, 3);
    drain(1);
    check("relaunch_pair_cnt", pc1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
